// File: rtl/sram_banked_mrd_pkg.sv
// Shared types and elaboration helpers for the banked multi-read buffer.
package sram_banked_mrd_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_e;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/sram_banked_mrd_bank.sv
// One bank: DEPTH x DATA_WIDTH storage, single write port, row clear,
// READ_WIDTH combinational read ports.
module sram_banked_mrd_bank
   import sram_banked_mrd_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 8,
   parameter int READ_WIDTH = 2,
   localparam int ROW_W     = idx_bits(DEPTH)
)(
   input  logic                                  i_clk,
   input  logic                                  we,
   input  logic [ROW_W-1:0]                      wrow,
   input  logic [DATA_WIDTH-1:0]                 wdata,
   input  logic                                  clr,
   input  logic [ROW_W-1:0]                      clr_row,
   input  logic [READ_WIDTH-1:0][ROW_W-1:0]      rrow,
   output logic [READ_WIDTH-1:0][DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Clear and write are never requested together; clear still takes priority.
   always_ff @(posedge i_clk) begin
      if (clr) begin
         mem[clr_row] <= '0;
      end else if (we) begin
         mem[wrow] <= wdata;
      end
   end

   for (genvar p = 0; p < READ_WIDTH; p++) begin : g_rd
      assign rdata[p] = mem[rrow[p]];
   end

endmodule

// File: rtl/sram_banked_mrd.sv
// Banked buffer: one wide rotating write port, READ_WIDTH element read ports
// with write-first bypass, 1- or 2-cycle read latency and a row-sweep clear.
//
// state   | meaning
// S_CLEAR | zeroing row row_q of every bank, reads/writes ignored
// S_IDLE  | ready, reads and writes accepted
module sram_banked_mrd
   import sram_banked_mrd_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int DATA_WIDTH   = 8,
   parameter int WRITE_WIDTH  = 4,
   parameter int READ_WIDTH   = 2,
   parameter int READ_LATENCY = 1,
   parameter int ADDR_WIDTH   = $clog2(DEPTH*WRITE_WIDTH)
)(
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_clear,
   input  logic                                  i_write_en,
   input  logic [0:WRITE_WIDTH-1]                i_write_strb,
   input  logic [ADDR_WIDTH-1:0]                 i_write_addr,
   input  logic [0:WRITE_WIDTH-1][DATA_WIDTH-1:0] i_data_in,
   input  logic                                  i_read_en,
   input  logic [0:READ_WIDTH-1][ADDR_WIDTH-1:0] i_read_addr,
   output logic [0:READ_WIDTH-1][DATA_WIDTH-1:0] o_data_out,
   output logic                                  o_read_valid,
   output logic                                  o_ready
);

   localparam int BANK_W = idx_bits(WRITE_WIDTH);
   localparam int ROW_W  = idx_bits(DEPTH);

   if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("sram_banked_mrd: READ_LATENCY must be 1 or 2");
   end

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               wr_ok, rd_ok, clr_en;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      case (state_q)
         S_IDLE: begin
            if (i_clear) begin
               state_d = S_CLEAR;
               row_d   = '0;
            end
         end
         S_CLEAR: begin
            if (i_clear) begin
               row_d = '0;
            end else if (row_q == ROW_W'(DEPTH-1)) begin
               state_d = S_IDLE;
               row_d   = '0;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         default: begin
            state_d = S_CLEAR;
            row_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_CLEAR;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   assign o_ready = (state_q == S_IDLE);
   // A clear request in IDLE beats a concurrent write; reads that cycle still see old data.
   assign wr_ok   = i_write_en & o_ready & ~i_clear & ~i_rst;
   assign rd_ok   = i_read_en & o_ready & ~i_rst;
   assign clr_en  = (state_q == S_CLEAR) & ~i_rst;

   logic [WRITE_WIDTH-1:0]                 bank_we;
   logic [ROW_W-1:0]                       bank_wrow  [WRITE_WIDTH];
   logic [DATA_WIDTH-1:0]                  bank_wdata [WRITE_WIDTH];
   logic [READ_WIDTH-1:0][DATA_WIDTH-1:0]  bank_rdata [WRITE_WIDTH];
   logic [READ_WIDTH-1:0][ROW_W-1:0]       rd_row;
   logic [0:READ_WIDTH-1][DATA_WIDTH-1:0]  rd_data;

   // Bank b receives the element whose address lands on it after rotation.
   for (genvar b = 0; b < WRITE_WIDTH; b++) begin : g_bank
      logic [BANK_W-1:0] elem;

      assign elem          = BANK_W'(b) - i_write_addr[BANK_W-1:0];
      assign bank_we[b]    = wr_ok & i_write_strb[elem];
      assign bank_wrow[b]  = ROW_W'((i_write_addr + ADDR_WIDTH'(elem)) >> BANK_W);
      assign bank_wdata[b] = i_data_in[elem];

      sram_banked_mrd_bank #(
         .DEPTH      (DEPTH),
         .DATA_WIDTH (DATA_WIDTH),
         .READ_WIDTH (READ_WIDTH)
      ) u_bank (
         .i_clk   (i_clk),
         .we      (bank_we[b]),
         .wrow    (bank_wrow[b]),
         .wdata   (bank_wdata[b]),
         .clr     (clr_en),
         .clr_row (row_q),
         .rrow    (rd_row),
         .rdata   (bank_rdata[b])
      );
   end

   for (genvar p = 0; p < READ_WIDTH; p++) begin : g_port
      logic [BANK_W-1:0]     rbank;
      logic [DATA_WIDTH-1:0] pdata;

      assign rbank     = i_read_addr[p][BANK_W-1:0];
      assign rd_row[p] = i_read_addr[p][ADDR_WIDTH-1:BANK_W];

      always_comb begin
         pdata = bank_rdata[rbank][p];
         for (int k = 0; k < WRITE_WIDTH; k++) begin
            if (wr_ok && i_write_strb[BANK_W'(k)] &&
                ((i_write_addr + ADDR_WIDTH'(k)) == i_read_addr[p])) begin
               pdata = i_data_in[BANK_W'(k)];
            end
         end
      end

      assign rd_data[p] = pdata;
   end

   logic                                  fin_vld;
   logic [0:READ_WIDTH-1][DATA_WIDTH-1:0] fin_data;

   if (READ_LATENCY == 2) begin : g_lat2
      logic                                  stg_vld;
      logic [0:READ_WIDTH-1][DATA_WIDTH-1:0] stg_data;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            stg_vld  <= 1'b0;
            stg_data <= '0;
         end else begin
            stg_vld  <= rd_ok;
            stg_data <= rd_data;
         end
      end

      assign fin_vld  = stg_vld;
      assign fin_data = stg_data;
   end else begin : g_lat1
      assign fin_vld  = rd_ok;
      assign fin_data = rd_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_read_valid <= 1'b0;
         o_data_out   <= '0;
      end else begin
         o_read_valid <= fin_vld;
         if (fin_vld) begin
            o_data_out <= fin_data;
         end
      end
   end

endmodule

// File: tb/tb_sram_banked_mrd.sv
// Self-checking bench for sram_banked_mrd: directed scenarios plus a randomized
// run against a flat-array reference of the element address space.
module tb_sram_banked_mrd;

   localparam int RL = 1;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_clear;
   logic              i_write_en;
   logic [0:3]        i_write_strb;
   logic [7:0]        i_write_addr;
   logic [0:3][7:0]   i_data_in;
   logic              i_read_en;
   logic [0:1][7:0]   i_read_addr;
   logic [0:1][7:0]   o_data_out;
   logic              o_read_valid;
   logic              o_ready;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   sram_banked_mrd #(
      .DEPTH        (64),
      .DATA_WIDTH   (8),
      .WRITE_WIDTH  (4),
      .READ_WIDTH   (2),
      .READ_LATENCY (RL)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (i_clear),
      .i_write_en   (i_write_en),
      .i_write_strb (i_write_strb),
      .i_write_addr (i_write_addr),
      .i_data_in    (i_data_in),
      .i_read_en    (i_read_en),
      .i_read_addr  (i_read_addr),
      .o_data_out   (o_data_out),
      .o_read_valid (o_read_valid),
      .o_ready      (o_ready)
   );

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      int         due;
   } rd_exp_t;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_clear      = 1'b0;
      i_write_en   = 1'b0;
      i_write_strb = '0;
      i_write_addr = '0;
      i_data_in    = '0;
      i_read_en    = 1'b0;
      i_read_addr  = '0;
   endtask

   task automatic issue(input bit we, input logic [0:3] strb, input logic [7:0] waddr,
                        input logic [0:3][7:0] wd, input bit re, input logic [7:0] ra0,
                        input logic [7:0] ra1, input bit clr);
      i_write_en   = we;
      i_write_strb = strb;
      i_write_addr = waddr;
      i_data_in    = wd;
      i_read_en    = re;
      i_read_addr  = {ra0, ra1};
      i_clear      = clr;
      tick();
      idle_inputs();
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (o_read_valid !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      int n;
      int lat;
      i_rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      n_checks++;
      if (o_ready !== 1'b0 || o_read_valid !== 1'b0 || o_data_out !== 16'h0000)
         $display("FAIL reset_outputs: ready=%b valid=%b data=%h, need 0 0 0000",
                  o_ready, o_read_valid, o_data_out);
      else n_pass++;
      i_rst = 1'b0;
      n = 0;
      while (o_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 64) $display("FAIL reset_sweep_len: ready after %0d cycles, need 64", n);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd0, 8'd255, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL) $display("FAIL reset_read_latency: got %0d, need %0d", lat, RL);
      else n_pass++;
      n_checks++;
      if (o_data_out !== 16'h0000) $display("FAIL reset_read_data: got %h, need 0000", o_data_out);
      else n_pass++;
      tick();
      n_checks++;
      if (o_read_valid !== 1'b0) $display("FAIL valid_pulse: valid=%b, need 0", o_read_valid);
      else n_pass++;
   endtask

   task automatic test_write_read();
      int lat;
      issue(1, 4'b1111, 8'd0, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0, 8'd0, 8'd0, 0);
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd1, 8'd0, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL) $display("FAIL write_read_latency: got %0d, need %0d", lat, RL);
      else n_pass++;
      n_checks++;
      if (o_data_out !== {8'hB2, 8'hA1}) $display("FAIL write_read_data: got %h, need b2a1", o_data_out);
      else n_pass++;
      tick();
      n_checks++;
      if (o_data_out !== {8'hB2, 8'hA1}) $display("FAIL data_hold: got %h, need b2a1", o_data_out);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int lat;
      issue(1, 4'b1111, 8'd254, {8'h11, 8'h22, 8'h33, 8'h44}, 0, 8'd0, 8'd0, 0);
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd255, 8'd1, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h22, 8'h44})
         $display("FAIL wrap_read_a: got %h lat %0d, need 2244 lat %0d", o_data_out, lat, RL);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd0, 8'd254, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h33, 8'h11})
         $display("FAIL wrap_read_b: got %h lat %0d, need 3311 lat %0d", o_data_out, lat, RL);
      else n_pass++;
   endtask

   task automatic test_strobe();
      int lat;
      issue(1, 4'b1010, 8'd8, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, 8'd0, 8'd0, 0);
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd9, 8'd10, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h00, 8'hCC})
         $display("FAIL strobe_read_a: got %h lat %0d, need 00cc", o_data_out, lat);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd8, 8'd8, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'hAA, 8'hAA})
         $display("FAIL strobe_read_dup: got %h lat %0d, need aaaa", o_data_out, lat);
      else n_pass++;
   endtask

   task automatic test_bypass();
      int lat;
      issue(1, 4'b1111, 8'd16, {8'h01, 8'h02, 8'h03, 8'h04}, 1, 8'd17, 8'd20, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h02, 8'h00})
         $display("FAIL bypass_read: got %h lat %0d, need 0200", o_data_out, lat);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd16, 8'd19, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h01, 8'h04})
         $display("FAIL bypass_stored: got %h lat %0d, need 0104", o_data_out, lat);
      else n_pass++;
   endtask

   task automatic test_clear();
      int  lat;
      int  c0;
      bit  saw_valid;
      // Read issued with the clear request must return pre-clear data.
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd2, 8'd3, 1);
      c0 = cyc;
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'hC3, 8'hD4})
         $display("FAIL clear_inflight_read: got %h lat %0d, need c3d4", o_data_out, lat);
      else n_pass++;
      issue(1, 4'b1111, 8'd40, {8'h77, 8'h77, 8'h77, 8'h77}, 1, 8'd40, 8'd41, 0);
      saw_valid = 1'b0;
      for (int i = 0; i < RL + 1; i++) begin
         if (o_read_valid === 1'b1) saw_valid = 1'b1;
         tick();
      end
      n_checks++;
      if (saw_valid) $display("FAIL clear_read_ignored: valid seen during clear, need none");
      else n_pass++;
      while (o_ready !== 1'b1 && (cyc - c0) < 200) tick();
      n_checks++;
      if ((cyc - c0) !== 64) $display("FAIL clear_sweep_len: ready after %0d cycles, need 64", cyc - c0);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd0, 8'd1, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== 16'h0000)
         $display("FAIL clear_zeroed: got %h lat %0d, need 0000", o_data_out, lat);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd40, 8'd2, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== 16'h0000)
         $display("FAIL clear_write_dropped: got %h lat %0d, need 0000", o_data_out, lat);
      else n_pass++;

      issue(1, 4'b1111, 8'd5, {8'h5A, 8'h6B, 8'h7C, 8'h8D}, 0, 8'd0, 8'd0, 0);
      issue(0, 4'b0000, 8'd0, '0, 1, 8'd5, 8'd8, 0);
      wait_valid(lat);
      n_checks++;
      if (lat !== RL || o_data_out !== {8'h5A, 8'h8D})
         $display("FAIL post_clear_write: got %h lat %0d, need 5a8d", o_data_out, lat);
      else n_pass++;
      issue(0, 4'b0000, 8'd0, '0, 0, 8'd0, 8'd0, 1);
      c0 = cyc;
      while ((cyc - c0) < 30) tick();
      n_checks++;
      if (o_ready !== 1'b0) $display("FAIL mid_clear_ready: got %b, need 0", o_ready);
      else n_pass++;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      c0 = cyc;
      n_checks++;
      if (o_data_out !== 16'h0000 || o_read_valid !== 1'b0 || o_ready !== 1'b0)
         $display("FAIL mid_clear_reset_outputs: data=%h valid=%b ready=%b, need 0000 0 0",
                  o_data_out, o_read_valid, o_ready);
      else n_pass++;
      while (o_ready !== 1'b1 && (cyc - c0) < 200) tick();
      n_checks++;
      if ((cyc - c0) !== 64) $display("FAIL reset_restart_len: ready after %0d cycles, need 64", cyc - c0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0]      ref_mem [256];
      rd_exp_t         q [$];
      rd_exp_t         e;
      bit              we;
      bit              re;
      bit              exp_vld;
      logic [0:3]      strb;
      logic [7:0]      waddr;
      logic [0:3][7:0] wd;
      logic [7:0]      ra0;
      logic [7:0]      ra1;
      for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
      for (int it = 0; it < 400 + RL; it++) begin
         if (it < 400) begin
            we    = ($urandom_range(0, 1) == 1);
            re    = ($urandom_range(0, 3) != 0);
            strb  = 4'($urandom);
            waddr = 8'($urandom);
            wd    = 32'($urandom);
            ra0   = ($urandom_range(0, 2) == 0) ? 8'(waddr + $urandom_range(0, 3)) : 8'($urandom);
            ra1   = ($urandom_range(0, 2) == 0) ? 8'(waddr + $urandom_range(0, 3)) : 8'($urandom);
         end else begin
            we = 1'b0;
            re = 1'b0;
            strb = '0; waddr = '0; wd = '0; ra0 = '0; ra1 = '0;
         end
         if (we) begin
            for (int k = 0; k < 4; k++)
               if (strb[k]) ref_mem[8'(waddr + k)] = wd[k];
         end
         if (re) begin
            e.d0  = ref_mem[ra0];
            e.d1  = ref_mem[ra1];
            e.due = cyc + RL;
            q.push_back(e);
         end
         issue(we, strb, waddr, wd, re, ra0, ra1, 0);
         exp_vld = (q.size() > 0) && (q[0].due == cyc);
         n_checks++;
         if (o_read_valid !== exp_vld)
            $display("FAIL rand_valid: cycle %0d valid=%b, need %b", cyc, o_read_valid, exp_vld);
         else n_pass++;
         if (exp_vld) begin
            e = q.pop_front();
            n_checks++;
            if (o_data_out !== {e.d0, e.d1})
               $display("FAIL rand_data: cycle %0d got %h, need %h", cyc, o_data_out, {e.d0, e.d1});
            else n_pass++;
         end
      end
      n_checks++;
      if (q.size() !== 0) $display("FAIL rand_drain: %0d reads outstanding, need 0", q.size());
      else n_pass++;
   endtask

   initial begin
      i_rst = 1'b1;
      idle_inputs();
      test_reset();
      test_write_read();
      test_wrap();
      test_strobe();
      test_bypass();
      test_clear();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
